open_ntt_poly_unload: RTL and testbench

Read-out engine for the OpenNTT polynomial memories. It is the counterpart of the host load path: on command it reads a selected poly memory and streams its contents to the software interface over a valid/ready channel. Because the intt_dif_rn/DIF flows leave results in bit-reversed order, it can traverse addresses in natural or bit-reversed order. It sits between the poly memory read ports and the host-side output FIFO.

---
 rtl/open_ntt_poly_unload.sv | 101 ++++++++++
 tb/tb_open_ntt_poly_unload.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/open_ntt_poly_unload.sv
// open_ntt_poly_unload: streams a poly memory to the host in natural or bit-reversed word order.
module open_ntt_poly_unload #(
    parameter int LOGN = 10,
    parameter int LOGQ = 128,
    parameter int PE = 1,
    parameter int NUM_POLY_MEMS = 2,
    parameter int MAX_NUM_POLY_MEMS = 4,
    localparam int SW = $clog2(MAX_NUM_POLY_MEMS),
    localparam int AW = LOGN - $clog2(PE),
    localparam int DW = PE * LOGQ
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start_i,
    input  logic [SW-1:0] mem_sel_i,
    input  logic          bitrev_i,
    output logic          busy_o,
    output logic          done_o,
    output logic          err_o,
    output logic          rd_en_o,
    output logic [SW-1:0] rd_sel_o,
    output logic [AW-1:0] rd_addr_o,
    input  logic [DW-1:0] rd_data_i,
    output logic [DW-1:0] m_data_o,
    output logic          m_valid_o,
    output logic          m_last_o,
    input  logic          m_ready_i
);
    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
    state_t state, state_nx;
    logic [AW-1:0] cnt, rev;
    logic rbit, pend, pend_last, wp, rp, pop, sel_ok, accept, room;
    logic [DW-1:0] fifo_q [2];
    logic [1:0] lst_q, occ;

    assign pop = m_valid_o && m_ready_i;
    assign sel_ok = {1'b0, mem_sel_i} < (SW+1)'(NUM_POLY_MEMS);
    assign accept = state == IDLE && start_i && !done_o && sel_ok;
    // a word leaving this cycle frees its slot, which keeps the stream at one word per cycle
    assign room = occ + {1'b0, pend} - {1'b0, pop} < 2'd2;
    assign busy_o = state != IDLE || done_o;
    assign m_valid_o = occ != 2'd0;
    assign m_data_o = fifo_q[rp];
    assign m_last_o = m_valid_o && lst_q[rp];
    assign rd_addr_o = rbit ? rev : cnt;

    always_comb begin
        rev = '0;
        for (int i = 0; i < AW; i++) rev[i] = cnt[AW-1-i];
    end

    always_ff @(posedge clk or posedge rst)
        if (rst) state <= IDLE;
        else state <= state_nx;

    always_comb begin
        state_nx = state == IDLE ? (accept ? RUN : IDLE)
                 : state == RUN  ? (rd_en_o && cnt == '1 ? DRAIN : RUN)
                 : (pop && m_last_o ? IDLE : DRAIN);
    end

    always_comb begin
        rd_en_o = state == RUN && room;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
            rbit <= 1'b0;
            rd_sel_o <= '0;
            pend <= 1'b0;
            pend_last <= 1'b0;
            done_o <= 1'b0;
            err_o <= 1'b0;
            fifo_q <= '{default: '0};
            lst_q <= '0;
            wp <= 1'b0;
            rp <= 1'b0;
            occ <= '0;
        end else begin
            done_o <= state == DRAIN && pop && m_last_o;
            err_o <= state == IDLE && start_i && !done_o && !sel_ok;
            pend <= rd_en_o;
            pend_last <= rd_en_o && cnt == '1;
            if (accept) begin
                cnt <= '0;
                rbit <= bitrev_i;
                rd_sel_o <= mem_sel_i;
            end else if (rd_en_o) begin
                cnt <= cnt + AW'(1);
            end
            if (pend) begin
                fifo_q[wp] <= rd_data_i;
                lst_q[wp] <= pend_last;
                wp <= ~wp;
            end
            if (pop) rp <= ~rp;
            occ <= occ + {1'b0, pend} - {1'b0, pop};
        end
    end
endmodule

// File: tb/tb_open_ntt_poly_unload.sv
// tb_open_ntt_poly_unload: directed checks of ordering, latency, backpressure, errors and reset.
module tb_open_ntt_poly_unload;
    logic clk = 0, rst = 1, start0 = 0, start1 = 0, br = 0, ready = 1, cur = 0;
    logic [1:0] sel = 0;
    logic busy0, done0, err0, rden0, valid0, last0, busy1, done1, err1, rden1, valid1, last1;
    logic [1:0] rsel0, rsel1;
    logic [3:0] addr0;
    logic [2:0] addr1;
    logic [15:0] rd0, data0;
    logic [31:0] rd1, data1;
    logic [15:0] mem0 [4][16];
    logic [31:0] mem1 [4][8];
    int n_chk = 0, n_pass = 0;

    always #5 clk = ~clk;

    open_ntt_poly_unload #(.LOGN(4), .LOGQ(16), .PE(1), .NUM_POLY_MEMS(2), .MAX_NUM_POLY_MEMS(4)) u0 (
        .clk(clk), .rst(rst), .start_i(start0), .mem_sel_i(sel), .bitrev_i(br),
        .busy_o(busy0), .done_o(done0), .err_o(err0), .rd_en_o(rden0), .rd_sel_o(rsel0),
        .rd_addr_o(addr0), .rd_data_i(rd0), .m_data_o(data0), .m_valid_o(valid0),
        .m_last_o(last0), .m_ready_i(ready));

    open_ntt_poly_unload #(.LOGN(4), .LOGQ(16), .PE(2), .NUM_POLY_MEMS(2), .MAX_NUM_POLY_MEMS(4)) u1 (
        .clk(clk), .rst(rst), .start_i(start1), .mem_sel_i(sel), .bitrev_i(br),
        .busy_o(busy1), .done_o(done1), .err_o(err1), .rd_en_o(rden1), .rd_sel_o(rsel1),
        .rd_addr_o(addr1), .rd_data_i(rd1), .m_data_o(data1), .m_valid_o(valid1),
        .m_last_o(last1), .m_ready_i(ready));

    always @(posedge clk) begin
        if (rden0) rd0 <= mem0[rsel0][addr0];
        if (rden1) rd1 <= mem1[rsel1][addr1];
    end

    logic c_busy, c_done, c_rden, c_valid, c_last;
    logic [1:0] c_sel;
    logic [31:0] c_data;
    assign c_busy = cur ? busy1 : busy0;
    assign c_done = cur ? done1 : done0;
    assign c_rden = cur ? rden1 : rden0;
    assign c_valid = cur ? valid1 : valid0;
    assign c_last = cur ? last1 : last0;
    assign c_sel = cur ? rsel1 : rsel0;
    assign c_data = cur ? data1 : {16'h0, data0};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        else n_pass++;
    endtask

    function automatic logic [31:0] expw(input bit d, input bit b, input int i);
        logic [3:0] x;
        x = 4'(i);
        if (d) return {16'(2*i+1), 16'(2*i)};
        return b ? {28'h0, x[0], x[1], x[2], x[3]} : 32'(i);
    endfunction

    task automatic run(input bit d, input bit b, input bit rnd, input bit again);
        int k, hs, iss, dk, ndone, v_out, v_stall, v_sel, nw;
        bit pst, st;
        logic [31:0] pd;
        nw = d ? 8 : 16;
        hs = 0; iss = 0; dk = 0; ndone = 0; v_out = 0; v_stall = 0; v_sel = 0; pst = 0; pd = 0;
        cur = d; sel = 2'(d); br = b; ready = 1;
        @(posedge clk); #1;
        if (d) start1 = 1; else start0 = 1;
        @(posedge clk); #1;
        start0 = 0; start1 = 0;
        k = 1;
        while (k < 400 && (dk == 0 || k <= dk + 1)) begin
            @(negedge clk);
            if (k == 1) begin
                chk("busy_t1", 32'(c_busy), 1);
                chk("rden_t1", 32'(c_rden), 1);
            end
            if (k == 2) chk("valid_t2", 32'(c_valid), 0);
            if (dk != 0 && k == dk + 1) chk("busy_after_done", 32'(c_busy), 0);
            if (c_busy && c_sel != 2'(d)) v_sel++;
            if (pst && (c_data !== pd || !c_valid)) v_stall++;
            if (c_rden && iss - hs - int'(c_valid && ready) >= 2) v_out++;
            if (c_valid && ready) begin
                chk("data", c_data, expw(d, b, hs));
                chk("last", 32'(c_last), 32'(hs == nw - 1));
                if (!rnd) chk("beat_cycle", k, 3 + hs);
                hs++;
            end
            if (c_rden) iss++;
            if (c_done) begin
                ndone++;
                if (dk == 0) dk = k;
            end
            pst = c_valid && !ready;
            pd = c_data;
            @(posedge clk); #1;
            st = again && k + 1 == 4;
            br = st ? ~b : b;
            if (d) start1 = st; else start0 = st;
            if (rnd) ready = 1'($urandom_range(0, 1));
            k++;
        end
        start0 = 0; start1 = 0; br = b; ready = 1;
        chk("words", hs, nw);
        chk("reads", iss, nw);
        chk("done_count", ndone, 1);
        if (!rnd) chk("done_cycle", dk, nw + 3);
        chk("outstanding_viol", v_out, 0);
        chk("stall_viol", v_stall, 0);
        chk("rd_sel_viol", v_sel, 0);
    endtask

    initial begin
        int hs, nd, nr;
        for (int m = 0; m < 4; m++) begin
            for (int i = 0; i < 16; i++) mem0[m][i] = (m == 0) ? 16'(i) : 16'(16'hA000 + m * 256 + i);
            for (int i = 0; i < 8; i++) mem1[m][i] = (m == 1) ? {16'(2*i+1), 16'(2*i)} : 32'(32'hDEAD0000 + m * 256 + i);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_ctrl0", {26'h0, busy0, done0, err0, rden0, valid0, last0}, 0);
        chk("reset_ctrl1", {26'h0, busy1, done1, err1, rden1, valid1, last1}, 0);
        chk("reset_addr_sel", {25'h0, addr1, addr0}, 0);
        chk("reset_data", data1 | {16'h0, data0}, 0);
        @(posedge clk); #1;
        rst = 0;

        run(0, 0, 0, 0);
        run(0, 1, 0, 0);
        run(1, 0, 0, 0);
        run(0, 0, 1, 0);
        run(1, 0, 1, 0);
        run(0, 1, 1, 0);
        run(0, 0, 0, 1);

        // invalid selector
        cur = 0; sel = 3;
        @(posedge clk); #1;
        start0 = 1;
        @(posedge clk); #1;
        start0 = 0;
        @(negedge clk);
        chk("err_pulse", 32'(err0), 1);
        chk("err_busy", 32'(busy0), 0);
        nr = int'(rden0) + int'(busy0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (i == 0) chk("err_one_cycle", 32'(err0), 0);
            nr += int'(rden0) + int'(busy0);
        end
        chk("err_no_activity", nr, 0);

        // reset in the middle of a transfer
        sel = 0; br = 0; ready = 1; hs = 0;
        @(posedge clk); #1;
        start0 = 1;
        @(posedge clk); #1;
        start0 = 0;
        for (int i = 0; i < 50 && hs < 5; i++) begin
            @(negedge clk);
            if (valid0 && ready) hs++;
        end
        chk("pre_reset_beats", hs, 5);
        @(posedge clk); #1;
        rst = 1;
        #1;
        chk("midrst_ctrl", {26'h0, busy0, done0, err0, rden0, valid0, last0}, 0);
        chk("midrst_addr", 32'(addr0), 0);
        chk("midrst_data", 32'(data0), 0);
        nd = 0;
        repeat (2) @(posedge clk);
        #1;
        rst = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            nd += int'(done0) + int'(valid0);
        end
        chk("midrst_quiet", nd, 0);
        run(0, 0, 0, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
